// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// The state_ctrl function maps each state to its Moore control word.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       mem_req;
        logic       illegal_op;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
            S_MEMADR:   begin c.alu_src_a = SRCA_RS1;   c.alu_src_b = SRCB_IMM; end
            S_MEMREAD:  begin c.adr_src = 1'b1; c.mem_req = 1'b1; end
            S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; c.mem_req = 1'b1; end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT;
            end
            S_ALUWB:    begin c.reg_write = 1'b1; c.result_src = RES_ALUOUT; end
            S_BEQ: begin
                c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALUOP_SUB;
                c.branch    = 1'b1;     c.result_src = RES_ALUOUT;
            end
            S_JAL, S_JALR2: begin
                c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
                c.result_src = RES_ALUOUT; c.pc_update = 1'b1;
            end
            S_JALR1:    begin c.alu_src_a = SRCA_RS1;   c.alu_src_b = SRCB_IMM; end
            S_LUI:      begin c.alu_src_a = SRCA_ZERO;  c.alu_src_b = SRCB_IMM; end
            S_AUIPC:    begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
            S_ILLEGAL:  c.illegal_op = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_imm_src_decoder.sv
// Combinational opcode to immediate-format select; shared with the pipelined core.
module imm_src_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [2:0] o_imm_src
);

    always_comb begin
        o_imm_src = IMM_I;
        case (i_op)
            OP_LOAD, OP_ITYPE, OP_JALR: o_imm_src = IMM_I;
            OP_STORE:                   o_imm_src = IMM_S;
            OP_BRANCH:                  o_imm_src = IMM_B;
            OP_JAL:                     o_imm_src = IMM_J;
            OP_LUI, OP_AUIPC:           o_imm_src = IMM_U;
            default:                    o_imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute through a shared
// ALU and unified memory, with optional memory wait states and illegal-op trap.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 0,
    parameter int ILLEGAL_TRAP  = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ImmSrc,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctrl;
    ctrl_t            w_ctrl;
    logic [CNT_W-1:0] r_instret;
    logic             w_ready;
    logic             w_hold;
    logic             w_retire;

    imm_src_decoder u_imm_src_decoder (
        .i_op      (op),
        .o_imm_src (ImmSrc)
    );

    assign w_ready = (MEM_HANDSHAKE == 0) || mem_ready;
    assign w_hold  = !w_ready &&
                     ((r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BEQ;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR1;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
                    default: begin
                        if (ILLEGAL_TRAP != 0) w_next = S_ILLEGAL;
                        else                   w_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_STORE) w_next = S_MEMWRITE;
                else                w_next = S_MEMREAD;
            end
            S_MEMREAD:                            w_next = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL, S_JALR2,
            S_LUI, S_AUIPC:                       w_next = S_ALUWB;
            S_JALR1:                              w_next = S_JALR2;
            default:                              w_next = S_FETCH;
        endcase
        if (w_hold) w_next = r_state;
    end

    // A silent DECODE->FETCH (trap disabled) still counts as a retirement.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_ILLEGAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ctrl    <= state_ctrl(S_FETCH);
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
            if (w_retire) r_instret <= r_instret + CNT_ONE;
        end
    end

    // Side-effecting strobes fire only on the cycle the memory completes.
    always_comb begin
        w_ctrl = r_ctrl;
        if (rst) begin
            w_ctrl            = state_ctrl(S_FETCH);
            w_ctrl.pc_update  = 1'b0;
            w_ctrl.branch     = 1'b0;
            w_ctrl.ir_write   = 1'b0;
            w_ctrl.mem_write  = 1'b0;
            w_ctrl.reg_write  = 1'b0;
            w_ctrl.mem_req    = 1'b0;
            w_ctrl.illegal_op = 1'b0;
        end else if (w_hold) begin
            w_ctrl.pc_update = 1'b0;
            w_ctrl.ir_write  = 1'b0;
            w_ctrl.mem_write = 1'b0;
        end
    end

    assign mem_req    = w_ctrl.mem_req;
    assign PCWrite    = w_ctrl.pc_update | (w_ctrl.branch & zero);
    assign AdrSrc     = w_ctrl.adr_src;
    assign IRWrite    = w_ctrl.ir_write;
    assign MemWrite   = w_ctrl.mem_write;
    assign RegWrite   = w_ctrl.reg_write;
    assign ResultSrc  = w_ctrl.result_src;
    assign ALUSrcA    = w_ctrl.alu_src_a;
    assign ALUSrcB    = w_ctrl.alu_src_b;
    assign ALUOp      = w_ctrl.alu_op;
    assign illegal_op = w_ctrl.illegal_op;
    assign instret    = r_instret;

endmodule
